vga_scanout: RTL
================

// Module: vga_scanout
// PURPOSE
//  Read side of the VGA frame memory. Generates VGA raster timing and fetches pixels through the memory read port (r_en/r_addr -> r_data/r_valid).
//  Prefetches pixels into a small FIFO and drives registered hsync/vsync/de/rgb to the DAC or encoder.
//  Retries reads dropped by write priority. Resynchronises the frame address every frame.
// PARAMETERS
//  ADDR_WIDTH  19   frame memory address width
//  DATA_WIDTH  24   pixel width, RGB 8:8:8
//  PIX_DIV     2    clk cycles per pixel; must be >= 2
//  FIFO_DEPTH  16   pixel prefetch FIFO depth; power of 2, >= 4
//  H_ACTIVE/H_FP/H_SYNC/H_BP  640/16/96/48  horizontal timing, in pixels
//  V_ACTIVE/V_FP/V_SYNC/V_BP  480/10/2/33   vertical timing, in lines
// PORTS
//  clk          in   1           system clock; one clock domain
//  rst          in   1           asynchronous, active-low reset
//  r_en         out  1           memory read request, one-cycle pulse
//  r_addr       out  ADDR_WIDTH  linear pixel address, y*H_ACTIVE+x
//  r_data       in   DATA_WIDTH  memory read data
//  r_valid      in   1           r_data valid; cycle after an accepted r_en
//  hsync        out  1           horizontal sync, active low
//  vsync        out  1           vertical sync, active low
//  de           out  1           display enable (active video)
//  rgb          out  DATA_WIDTH  pixel out; 0 when de=0 or on underrun
//  frame_start  out  1           one-cycle pulse: first pixel of frame on outputs
//  underrun     out  1           one-cycle pulse: active pixel found FIFO empty
// BEHAVIOUR
//  Reset (rst=0, async): r_en=0, r_addr=0, hsync=1, vsync=1, de=0, rgb=0, frame_start=0, underrun=0.
//   Also during reset: FIFO empty, fetch FSM IDLE, h_cnt=0, v_cnt=V_ACTIVE (vertical front porch).
//   Starting in the front porch lets the first frame prefetch before active video.
//  Pixel tick: divider pulses pix_en once every PIX_DIV clks.
//   On pix_en, h_cnt advances 0..H_TOTAL-1; at wrap, v_cnt advances 0..V_TOTAL-1.
//   Active region: h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
//   hsync low for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vsync uses the same rule on v_cnt.
//  Output stage: all video outputs registered, updated on the clk after pix_en; hsync/vsync/de/rgb mutually aligned.
//   Active pixel, FIFO non-empty: pop FIFO, rgb=head.
//   Active pixel, FIFO empty: rgb=0, de=1, underrun pulses one cycle, no pop.
//   frame_start pulses with the output of pixel (0,0).
//  Flush: on the pix_en that enters vsync (v_cnt=V_ACTIVE+V_FP, h_cnt=0):
//   FIFO cleared, fetch address reset to 0, fetched-pixel count cleared.
//   Any read in flight is discarded: its r_valid data is not pushed.
//  Fetch FSM:
//   F_IDLE -> F_WAIT when FIFO count < FIFO_DEPTH and fetched count < H_ACTIVE*V_ACTIVE and no flush this cycle.
//    This transition asserts r_en for one cycle with r_addr=fetch_addr.
//   F_WAIT, r_valid=1: push r_data, fetch_addr++, go F_IDLE.
//   F_WAIT, r_valid=0 (read lost to a memory write): go F_IDLE; same address is re-issued next time.
//   The FSM never issues while in F_WAIT: at most one read outstanding, peak one read per 2 clks.
//   Fetching stops after H_ACTIVE*V_ACTIVE pixels and resumes only after the next flush.
//   Slack built up during blanking absorbs write stalls.
//  Simultaneous push and pop in one cycle: both happen, count unchanged. Push when full is impossible by construction.
//  Widths: h_cnt/v_cnt are $clog2(H_TOTAL)/$clog2(V_TOTAL) bits. fetch_addr is ADDR_WIDTH bits and never wraps within a frame.
// STRUCTURE
//  vga_pkg: timing defaults, H_TOTAL/V_TOTAL localparams, fetch state enum (F_IDLE, F_WAIT).
//  Sub-module vga_pixel_fifo: sync FIFO with push/pop/flush/count.
//   Ptr-based, show-ahead head, count 0..FIFO_DEPTH.
//  Top holds the timing counters, fetch FSM and output registers.
// TESTING
//  Use sim timing H=8/1/2/1, V=4/1/1/1, PIX_DIV=2, memory model preloaded mem[a]=a.
//  1 Reset: rst=0 mid-stream -> next edge-independent: r_en=0, hsync=vsync=1, de=0, rgb=0. Release -> first frame_start after 3 lines (v=4..6 blank), no underrun.
//  2 Clean frame: rgb over de cycles = 0,1,...,31, each held 2 clks; hsync low 2 pixels per line; vsync low 1 line; underrun never.
//  3 Collision: w_en=1 for 6 clks mid-line 1 -> r_en re-issued at same r_addr after each r_valid=0; pixel sequence intact; underrun=0.
//  4 Starvation: w_en=1 for all of line 2 -> underrun pulses, rgb=0 with de=1; next frame starts again at rgb=0 after flush.
//  5 Flush in flight: r_valid returns in the flush cycle -> data dropped; first push after flush carries mem[0].
//  6 Reset mid-read: rst=0 while F_WAIT -> r_en=0 immediately; after release, fetch restarts at r_addr=0.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared timing defaults and fetch FSM encoding for the VGA scanout path.
// No logic of its own; latency and backpressure are defined by the users.
package vga_pkg;

   localparam int ADDR_WIDTH_DEF = 19;
   localparam int DATA_WIDTH_DEF = 24;
   localparam int PIX_DIV_DEF    = 2;
   localparam int FIFO_DEPTH_DEF = 16;

   localparam int H_ACTIVE_DEF = 640;
   localparam int H_FP_DEF     = 16;
   localparam int H_SYNC_DEF   = 96;
   localparam int H_BP_DEF     = 48;
   localparam int V_ACTIVE_DEF = 480;
   localparam int V_FP_DEF     = 10;
   localparam int V_SYNC_DEF   = 2;
   localparam int V_BP_DEF     = 33;

   localparam int H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
   localparam int V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

   typedef enum logic {
      F_IDLE = 1'b0,
      F_WAIT = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/vga_pixel_fifo.sv
// Pixel prefetch FIFO: show-ahead head, 1-cycle push-to-head, flush clears in one cycle.
// No internal backpressure; the caller never pushes when full nor pops when empty.
module vga_pixel_fifo
   import vga_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int DEPTH      = FIFO_DEPTH_DEF
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic [DATA_WIDTH-1:0]        push_dat,
   input  logic                         pop,
   input  logic                         flush,
   output logic [DATA_WIDTH-1:0]        head,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         cnt_q, cnt_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         cnt_d = cnt_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage needs no reset: the count alone says what is valid.
   always_ff @(posedge clk) begin
      if (push && !flush) mem_q[wr_ptr_q] <= push_dat;
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = cnt_q;
   assign empty = (cnt_q == '0);

endmodule

// File: rtl/vga_scanout.sv
// VGA raster timing plus frame-memory read side; video outputs registered 1 clk after pix_en.
// Reads may be dropped by the memory (r_valid=0) and are re-issued; an empty FIFO shows black and flags underrun.
module vga_scanout
   import vga_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int PIX_DIV    = PIX_DIV_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
   parameter int H_ACTIVE   = H_ACTIVE_DEF,
   parameter int H_FP       = H_FP_DEF,
   parameter int H_SYNC     = H_SYNC_DEF,
   parameter int H_BP       = H_BP_DEF,
   parameter int V_ACTIVE   = V_ACTIVE_DEF,
   parameter int V_FP       = V_FP_DEF,
   parameter int V_SYNC     = V_SYNC_DEF,
   parameter int V_BP       = V_BP_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  r_en,
   output logic [ADDR_WIDTH-1:0] r_addr,
   input  logic [DATA_WIDTH-1:0] r_data,
   input  logic                  r_valid,
   output logic                  hsync,
   output logic                  vsync,
   output logic                  de,
   output logic [DATA_WIDTH-1:0] rgb,
   output logic                  frame_start,
   output logic                  underrun
);
   localparam int H_TOT     = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOT     = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW        = $clog2(H_TOT);
   localparam int VW        = $clog2(V_TOT);
   localparam int DVW       = $clog2(PIX_DIV);
   localparam int CW        = $clog2(FIFO_DEPTH + 1);
   localparam int FRAME_PIX = H_ACTIVE * V_ACTIVE;

   logic [DVW-1:0]        div_q, div_d;
   logic [HW-1:0]         h_cnt_q, h_cnt_d;
   logic [VW-1:0]         v_cnt_q, v_cnt_d;
   logic                  hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
   logic [DATA_WIDTH-1:0] rgb_q, rgb_d;
   logic                  frame_start_q, frame_start_d, underrun_q, underrun_d;
   fetch_state_t          state_q, state_d;
   logic [ADDR_WIDTH-1:0] fetch_addr_q, fetch_addr_d;
   logic                  run_q, run_d;

   logic                  pix_en, active, flush, pop, push, issue;
   logic [DATA_WIDTH-1:0] fifo_head;
   logic [CW-1:0]         fifo_cnt;
   logic                  fifo_empty;

   assign pix_en = (div_q == DVW'(PIX_DIV - 1));
   assign active = (h_cnt_q < HW'(H_ACTIVE)) && (v_cnt_q < VW'(V_ACTIVE));
   assign flush  = pix_en && (v_cnt_q == VW'(V_ACTIVE + V_FP)) && (h_cnt_q == '0);
   assign pop    = pix_en && active && !fifo_empty;

   always_comb begin
      div_d         = pix_en ? '0 : div_q + DVW'(1);
      h_cnt_d       = h_cnt_q;
      v_cnt_d       = v_cnt_q;
      hsync_d       = hsync_q;
      vsync_d       = vsync_q;
      de_d          = de_q;
      rgb_d         = rgb_q;
      frame_start_d = 1'b0;
      underrun_d    = 1'b0;
      if (pix_en) begin
         if (h_cnt_q == HW'(H_TOT - 1)) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == VW'(V_TOT - 1)) ? '0 : v_cnt_q + VW'(1);
         end else begin
            h_cnt_d = h_cnt_q + HW'(1);
         end
         hsync_d       = !((h_cnt_q >= HW'(H_ACTIVE + H_FP)) && (h_cnt_q < HW'(H_ACTIVE + H_FP + H_SYNC)));
         vsync_d       = !((v_cnt_q >= VW'(V_ACTIVE + V_FP)) && (v_cnt_q < VW'(V_ACTIVE + V_FP + V_SYNC)));
         de_d          = active;
         rgb_d         = pop ? fifo_head : '0;
         frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
         underrun_d    = active && fifo_empty;
      end
   end

   // Fetch address doubles as the fetched-pixel count: it only moves on a push and restarts at flush.
   always_comb begin
      state_d      = state_q;
      fetch_addr_d = fetch_addr_q;
      run_d        = 1'b1;
      issue        = 1'b0;
      push         = 1'b0;
      case (state_q)
         F_IDLE: begin
            if (run_q && (fifo_cnt < CW'(FIFO_DEPTH)) &&
                (fetch_addr_q < ADDR_WIDTH'(FRAME_PIX)) && !flush) begin
               issue   = 1'b1;
               state_d = F_WAIT;
            end
         end
         F_WAIT: begin
            state_d = F_IDLE;
            if (r_valid && !flush) begin
               push         = 1'b1;
               fetch_addr_d = fetch_addr_q + ADDR_WIDTH'(1);
            end
         end
         default: state_d = F_IDLE;
      endcase
      if (flush) fetch_addr_d = '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_q         <= '0;
         h_cnt_q       <= '0;
         v_cnt_q       <= VW'(V_ACTIVE);
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
         de_q          <= 1'b0;
         rgb_q         <= '0;
         frame_start_q <= 1'b0;
         underrun_q    <= 1'b0;
         state_q       <= F_IDLE;
         fetch_addr_q  <= '0;
         run_q         <= 1'b0;
      end else begin
         div_q         <= div_d;
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         de_q          <= de_d;
         rgb_q         <= rgb_d;
         frame_start_q <= frame_start_d;
         underrun_q    <= underrun_d;
         state_q       <= state_d;
         fetch_addr_q  <= fetch_addr_d;
         run_q         <= run_d;
      end
   end

   vga_pixel_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .push_dat (r_data),
      .pop      (pop),
      .flush    (flush),
      .head     (fifo_head),
      .count    (fifo_cnt),
      .empty    (fifo_empty)
   );

   // run_q keeps r_en low while reset is asserted, since the issue condition is otherwise true there.
   assign r_en        = issue;
   assign r_addr      = fetch_addr_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign de          = de_q;
   assign rgb         = rgb_q;
   assign frame_start = frame_start_q;
   assign underrun    = underrun_q;

endmodule
